// File: rtl/ex_mdu_pkg.sv
// Shared execute-stage definitions: ALU op/class codes, control constants and
// the multiply/divide state encoding.
package ex_mdu_pkg;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;

  // aluop codes
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  // alusel result classes
  localparam logic [2:0] EXE_RES_NOP         = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
  localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
  localparam logic [2:0] EXE_RES_MUL         = 3'b101;
  localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

  // multiply/divide state encoding
  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_BUSY = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  function automatic logic is_muldiv(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_mdu_core.sv
// Iterative radix-2 multiply/divide unit with its control FSM.
// Ports: clk/rst; start_i (mul/div op present), div_i (1=divide), signed_i,
// annul_i (abort); a_i/b_i operands; busy_o (stall request), done_o (result
// valid this cycle), hi_o/lo_o (HI = high half/remainder, LO = low/quotient).
module ex_mdu_core
  import ex_mdu_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          div_i,
  input  logic          signed_i,
  input  logic          annul_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam int unsigned CW = $clog2(DW) + 1;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0]   opnd_q, opnd_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic            div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic            a_neg, b_neg;
  logic [DW-1:0]   a_mag, b_mag;
  logic [DW:0]     mul_sum, div_trial;
  logic [2*DW-1:0] step_acc, prod_fix;

  assign a_neg = signed_i & a_i[DW-1];
  assign b_neg = signed_i & b_i[DW-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  assign mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_trial = acc_q[2*DW-1:DW-1] - {1'b0, opnd_q};

  always_comb begin
    step_acc = {mul_sum, acc_q[DW-1:1]};
    if (div_q) begin
      if (!div_trial[DW]) step_acc = {div_trial[DW-1:0], acc_q[DW-2:0], 1'b1};
      else                step_acc = {acc_q[2*DW-2:0], 1'b0};
    end
  end

  assign prod_fix = qneg_q ? -step_acc : step_acc;

  // Next-state and control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          busy_o = 1'b1;
          div_d  = div_i;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (div_i && (b_i == '0)) begin
            hi_d    = a_i;
            lo_d    = '1;
            state_d = MDU_DONE;
          end else begin
            opnd_d  = div_i ? b_mag : a_mag;
            acc_d   = {{DW{1'b0}}, (div_i ? a_mag : b_mag)};
            state_d = MDU_BUSY;
          end
        end
      end
      MDU_BUSY: begin
        busy_o = 1'b1;
        acc_d  = step_acc;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = MDU_DONE;
          if (div_q) begin
            hi_d = rneg_q ? -step_acc[2*DW-1:DW] : step_acc[2*DW-1:DW];
            lo_d = qneg_q ? -step_acc[DW-1:0]    : step_acc[DW-1:0];
          end else begin
            hi_d = prod_fix[2*DW-1:DW];
            lo_d = prod_fix[DW-1:0];
          end
        end
      end
      MDU_DONE: begin
        done_o  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    // Flush wins over everything, including a pending result.
    if (annul_i) begin
      state_d = MDU_IDLE;
      busy_o  = 1'b0;
      done_o  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/ex_mdu.sv
// MIPS execute stage: single-cycle ALU, HI/LO forwarding and a multi-cycle
// multiply/divide unit that stalls upstream while iterating.
// Ports: aluop_i/alusel_i select the op; rdata1_i/rdata2_i operands;
// waddr_reg_i/we_reg_i GPR dest; return_addr_i link address; hi_i/lo_i and
// mem_*/wb_* HI/LO sources; annul_i flush. Outputs: GPR writeback
// (waddr_reg_o/we_reg_o/wdata_o), HI/LO writeback (hi_o/lo_o/whilo_o),
// ovf_o overflow, stallreq_o pipeline hold. All outputs are combinational.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned RAW = 5,
  parameter int unsigned AW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     aluop_i,
  input  logic [2:0]     alusel_i,
  input  logic [DW-1:0]  rdata1_i,
  input  logic [DW-1:0]  rdata2_i,
  input  logic [RAW-1:0] waddr_reg_i,
  input  logic           we_reg_i,
  input  logic [AW-1:0]  return_addr_i,
  input  logic [DW-1:0]  hi_i,
  input  logic [DW-1:0]  lo_i,
  input  logic [DW-1:0]  mem_hi_i,
  input  logic [DW-1:0]  mem_lo_i,
  input  logic           mem_whilo_i,
  input  logic [DW-1:0]  wb_hi_i,
  input  logic [DW-1:0]  wb_lo_i,
  input  logic           wb_whilo_i,
  input  logic           annul_i,
  output logic [RAW-1:0] waddr_reg_o,
  output logic           we_reg_o,
  output logic [DW-1:0]  wdata_o,
  output logic [DW-1:0]  hi_o,
  output logic [DW-1:0]  lo_o,
  output logic           whilo_o,
  output logic           ovf_o,
  output logic           stallreq_o
);

  localparam int unsigned SHW = $clog2(DW);

  logic [DW-1:0]  fwd_hi, fwd_lo;
  logic [SHW-1:0] sa;
  logic [DW-1:0]  logic_res, shift_res, move_res, arith_res, result;
  logic [DW-1:0]  b_eff, sum;
  logic           is_sub, ovf;
  logic           md_busy, md_done;
  logic [DW-1:0]  md_hi, md_lo;
  logic [DW-1:0]  hilo_hi, hilo_lo;
  logic           hilo_we;

  // HI/LO forwarding: youngest producer (MEM) first
  always_comb begin
    fwd_hi = hi_i;
    fwd_lo = lo_i;
    if (mem_whilo_i) begin
      fwd_hi = mem_hi_i;
      fwd_lo = mem_lo_i;
    end else if (wb_whilo_i) begin
      fwd_hi = wb_hi_i;
      fwd_lo = wb_lo_i;
    end
  end

  ex_mdu_core #(.DW(DW)) u_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (is_muldiv(aluop_i)),
    .div_i    ((aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP)),
    .signed_i ((aluop_i == EXE_MULT_OP) || (aluop_i == EXE_DIV_OP)),
    .annul_i  (annul_i),
    .a_i      (rdata1_i),
    .b_i      (rdata2_i),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .hi_o     (md_hi),
    .lo_o     (md_lo)
  );

  assign sa = rdata1_i[SHW-1:0];

  // Shared adder: subtract as a + ~b + 1 so one overflow rule covers both
  assign is_sub = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
  assign b_eff  = is_sub ? ~rdata2_i : rdata2_i;
  assign sum    = rdata1_i + b_eff + DW'(is_sub);
  assign ovf    = (alusel_i == EXE_RES_ARITHMETIC) &&
                  ((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_SUB_OP)) &&
                  (rdata1_i[DW-1] == b_eff[DW-1]) && (sum[DW-1] != rdata1_i[DW-1]);

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = rdata1_i | rdata2_i;
      EXE_AND_OP: logic_res = rdata1_i & rdata2_i;
      EXE_NOR_OP: logic_res = ~(rdata1_i | rdata2_i);
      EXE_XOR_OP: logic_res = rdata1_i ^ rdata2_i;
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = rdata2_i << sa;
      EXE_SRL_OP: shift_res = rdata2_i >> sa;
      EXE_SRA_OP: shift_res = DW'($signed(rdata2_i) >>> sa);
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    move_res = '0;
    case (aluop_i)
      EXE_MFHI_OP:              move_res = fwd_hi;
      EXE_MFLO_OP:              move_res = fwd_lo;
      EXE_MOVZ_OP, EXE_MOVN_OP: move_res = rdata1_i;
      default:                  move_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP,
      EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
      EXE_SLT_OP:  arith_res = {{(DW-1){1'b0}}, ($signed(rdata1_i) < $signed(rdata2_i))};
      EXE_SLTU_OP: arith_res = {{(DW-1){1'b0}}, (rdata1_i < rdata2_i)};
      default:     arith_res = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (alusel_i)
      EXE_RES_LOGIC:       result = logic_res;
      EXE_RES_SHIFT:       result = shift_res;
      EXE_RES_MOVE:        result = move_res;
      EXE_RES_ARITHMETIC:  result = arith_res;
      EXE_RES_JUMP_BRANCH: result = DW'(return_addr_i);
      default:             result = '0;
    endcase
  end

  // HI/LO writeback: a finished mul/div result, else MTHI/MTLO
  always_comb begin
    hilo_we = 1'b0;
    hilo_hi = '0;
    hilo_lo = '0;
    if (md_done) begin
      hilo_we = 1'b1;
      hilo_hi = md_hi;
      hilo_lo = md_lo;
    end else if (aluop_i == EXE_MTHI_OP) begin
      hilo_we = 1'b1;
      hilo_hi = rdata1_i;
      hilo_lo = fwd_lo;
    end else if (aluop_i == EXE_MTLO_OP) begin
      hilo_we = 1'b1;
      hilo_hi = fwd_hi;
      hilo_lo = rdata1_i;
    end
  end

  // Output stage; reset forces everything low
  always_comb begin
    waddr_reg_o = waddr_reg_i;
    we_reg_o    = we_reg_i & ~ovf;
    wdata_o     = result;
    hi_o        = hilo_hi;
    lo_o        = hilo_lo;
    whilo_o     = hilo_we;
    ovf_o       = ovf;
    stallreq_o  = md_busy;
    if (rst) begin
      waddr_reg_o = '0;
      we_reg_o    = 1'b0;
      wdata_o     = '0;
      hi_o        = '0;
      lo_o        = '0;
      whilo_o     = 1'b0;
      ovf_o       = 1'b0;
      stallreq_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: expected results are queued when an op is issued
// and compared when the execute stage presents its output.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned RAW = 5;
  localparam int unsigned AW  = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     aluop_i;
  logic [2:0]     alusel_i;
  logic [DW-1:0]  rdata1_i, rdata2_i;
  logic [RAW-1:0] waddr_reg_i;
  logic           we_reg_i;
  logic [AW-1:0]  return_addr_i;
  logic [DW-1:0]  hi_i, lo_i, mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
  logic           mem_whilo_i, wb_whilo_i, annul_i;
  logic [RAW-1:0] waddr_reg_o;
  logic           we_reg_o;
  logic [DW-1:0]  wdata_o, hi_o, lo_o;
  logic           whilo_o, ovf_o, stallreq_o;

  always #5 clk = ~clk;

  ex_mdu #(.DW(DW), .RAW(RAW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
    .waddr_reg_i(waddr_reg_i), .we_reg_i(we_reg_i), .return_addr_i(return_addr_i),
    .hi_i(hi_i), .lo_i(lo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .mem_whilo_i(mem_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .wb_whilo_i(wb_whilo_i), .annul_i(annul_i),
    .waddr_reg_o(waddr_reg_o), .we_reg_o(we_reg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .ovf_o(ovf_o), .stallreq_o(stallreq_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] wdata;
    logic        we;
    logic        ovf;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference HI/LO results computed at 64-bit width
  function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa64, sb64, sp, sq, sr;
    logic [63:0]        up;
    sa64 = $signed({{32{a[31]}}, a});
    sb64 = $signed({{32{b[31]}}, b});
    hi = '0;
    lo = '0;
    case (op)
      EXE_MULT_OP: begin sp = sa64 * sb64; hi = sp[63:32]; lo = sp[31:0]; end
      EXE_MULTU_OP: begin up = {32'h0, a} * {32'h0, b}; hi = up[63:32]; lo = up[31:0]; end
      EXE_DIV_OP: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin sq = sa64 / sb64; sr = sa64 % sb64; hi = sr[31:0]; lo = sq[31:0]; end
      end
      EXE_DIVU_OP: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      default: ;
    endcase
  endfunction

  // New op one delta after the edge; also releases rst/annul
  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    annul_i  = 1'b0;
    aluop_i  = op;
    alusel_i = sel;
    rdata1_i = a;
    rdata2_i = b;
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=%0d exp=1", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".wdata"}, wdata_o, e.wdata);
      chk({e.tag, ".we"}, 32'(we_reg_o), 32'(e.we));
      chk({e.tag, ".ovf"}, 32'(ovf_o), 32'(e.ovf));
      chk({e.tag, ".whilo"}, 32'(whilo_o), 32'(e.whilo));
      chk({e.tag, ".stall"}, 32'(stallreq_o), 32'd0);
      chk({e.tag, ".waddr"}, 32'(waddr_reg_o), 32'd9);
      if (e.whilo) begin
        chk({e.tag, ".hi"}, hi_o, e.hi);
        chk({e.tag, ".lo"}, lo_o, e.lo);
      end
    end
  endtask

  task automatic alu_step(input string tag, input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_wd, input logic exp_we, input logic exp_ovf,
                          input logic exp_whilo, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(op, sel, a, b);
    sb.push_back('{tag, exp_wd, exp_we, exp_ovf, exp_whilo, exp_hi, exp_lo});
    @(negedge clk);
    check_out();
  endtask

  task automatic md_step(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    drive(op, EXE_RES_NOP, a, b);
    sb.push_back('{tag, 32'h0, 1'b1, 1'b0, 1'b1, exp_hi, exp_lo});
    n = 0;
    @(negedge clk);
    while (stallreq_o === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".stall_cycles"}, 32'(n), 32'(exp_stall));
    check_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ops [4];
    logic [31:0] a, b, mh, ml;
    ops[0] = EXE_MULT_OP; ops[1] = EXE_MULTU_OP; ops[2] = EXE_DIV_OP; ops[3] = EXE_DIVU_OP;

    rst = 1'b1; annul_i = 1'b0;
    aluop_i = EXE_MTHI_OP; alusel_i = EXE_RES_MOVE;
    rdata1_i = 32'h1234_5678; rdata2_i = 32'h0000_0001;
    waddr_reg_i = 5'd9; we_reg_i = 1'b1; return_addr_i = 32'h0040_0010;
    hi_i = 32'h1111_2222; lo_i = 32'h3333_4444;
    mem_hi_i = 32'hAAAA_0000; mem_lo_i = 32'hAAAA_1111; mem_whilo_i = 1'b0;
    wb_hi_i = 32'h0000_5555; wb_lo_i = 32'h0000_6666; wb_whilo_i = 1'b0;

    // Reset: everything low even with an op on the inputs
    @(negedge clk);
    chk("rst.whilo", 32'(whilo_o), 32'd0);
    chk("rst.we", 32'(we_reg_o), 32'd0);
    chk("rst.wdata", wdata_o, 32'd0);
    chk("rst.waddr", 32'(waddr_reg_o), 32'd0);
    aluop_i = EXE_MULT_OP;
    #1;
    chk("rst.stall", 32'(stallreq_o), 32'd0);

    // Single-cycle ALU
    alu_step("or",   EXE_OR_OP,   EXE_RES_LOGIC, 32'h0F0F_0000, 32'h00F0_F0F0, 32'h0FFF_F0F0, 1, 0, 0, 0, 0);
    alu_step("nor",  EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0F0F_0000, 32'h00F0_F0F0, 32'hF000_0F0F, 1, 0, 0, 0, 0);
    alu_step("xor",  EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1, 0, 0, 0, 0);
    alu_step("and",  EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1, 0, 0, 0, 0);
    alu_step("sll",  EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1, 0, 0, 0, 0);
    alu_step("srl",  EXE_SRL_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1, 0, 0, 0, 0);
    alu_step("sra",  EXE_SRA_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1, 0, 0, 0, 0);
    alu_step("add_ovf",  EXE_ADD_OP,  EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0, 0, 0);
    alu_step("addu",     EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0, 0, 0);
    alu_step("sub_ovf",  EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 0, 0, 0);
    alu_step("sub",      EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'h0000_0005, 32'h7, 32'hFFFF_FFFE, 1, 0, 0, 0, 0);
    alu_step("subu",     EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'h0000_0005, 32'h7, 32'hFFFF_FFFE, 1, 0, 0, 0, 0);
    alu_step("slt",      EXE_SLT_OP,  EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 1, 0, 0, 0, 0);
    alu_step("sltu",     EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 1, 0, 0, 0, 0);
    alu_step("movz", EXE_MOVZ_OP, EXE_RES_MOVE, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, 0, 0, 0, 0);

    // HI/LO forwarding priority
    mem_whilo_i = 1'b1; wb_whilo_i = 1'b1;
    alu_step("mfhi_mem", EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'hAAAA_0000, 1, 0, 0, 0, 0);
    mem_whilo_i = 1'b0;
    alu_step("mfhi_wb",  EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'h0000_5555, 1, 0, 0, 0, 0);
    alu_step("mflo_wb",  EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'h0000_6666, 1, 0, 0, 0, 0);
    wb_whilo_i = 1'b0;
    alu_step("mfhi_rf",  EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 32'h1111_2222, 1, 0, 0, 0, 0);
    alu_step("mthi", EXE_MTHI_OP, EXE_RES_NOP, 32'hCAFE_BABE, 32'h0, 32'h0, 1, 0, 1, 32'hCAFE_BABE, 32'h3333_4444);
    alu_step("mtlo", EXE_MTLO_OP, EXE_RES_NOP, 32'hCAFE_BABE, 32'h0, 32'h0, 1, 0, 1, 32'h1111_2222, 32'hCAFE_BABE);
    alu_step("jal",  EXE_NOP_OP, EXE_RES_JUMP_BRANCH, 32'h0, 32'h0, 32'h0040_0010, 1, 0, 0, 0, 0);
    alu_step("badsel", EXE_OR_OP, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0, 0);

    // Multiply/divide, back to back
    md_step("mult",  EXE_MULT_OP, 32'hFFFF_FFFD, 32'h7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    md_step("divu",  EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'h0000_0002, 32'h0000_000E);
    md_step("div",   EXE_DIV_OP,  32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_step("div0",  EXE_DIV_OP,  32'h5, 32'h0, 1, 32'h0000_0005, 32'hFFFF_FFFF);
    md_step("divu0", EXE_DIVU_OP, 32'h8000_0000, 32'h0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i[0]) b = b >> 20;
      if (b == 32'h0) b = 32'h1;
      model(ops[i % 4], a, b, mh, ml);
      md_step($sformatf("rnd%0d", i), ops[i % 4], a, b, 33, mh, ml);
    end

    // Flush during a divide
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    #1;
    chk("annul.busy_before", 32'(stallreq_o), 32'd1);
    annul_i = 1'b1;
    #1;
    chk("annul.stall", 32'(stallreq_o), 32'd0);
    chk("annul.whilo", 32'(whilo_o), 32'd0);
    alu_step("annul.addu", EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd3, 32'd4, 32'd7, 1, 0, 0, 0, 0);

    // Reset during a multiply
    drive(EXE_MULT_OP, EXE_RES_NOP, 32'h1234, 32'h5678);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid.stall", 32'(stallreq_o), 32'd0);
    chk("rstmid.whilo", 32'(whilo_o), 32'd0);
    alu_step("rstmid.addu", EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd10, 32'd20, 32'd30, 1, 0, 0, 0, 0);

    chk("sb.leftover", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
